// File: rtl/ft60x_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ft60x_pkg
//  Description : Shared definitions for the FT60x write streamer: operating
//                modes and a constant-evaluable ceil(log2) helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ft60x_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM  = 2'd0,   // drain the internal FIFO
        MODE_PATTERN = 2'd1,   // emit an incrementing counter
        MODE_IDLE    = 2'd2    // never write
    } mode_e;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ft_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head word is
//                read combinationally from the register array at the read
//                pointer, so it is valid whenever the FIFO is not empty.
//                A push while full and a pop while empty are ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i, data_i  - write request and word
//                pop_i           - consume head word
//                data_o          - head word
//                full_o          - no room for another word
//                empty_next_o    - FIFO will be empty after this edge
//                level_o         - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module ft_sync_fifo
    import ft60x_pkg::*;
#(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 512,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_next_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_empty = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i  & ~w_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_o       = mem[rd_ptr_q];
    assign empty_next_o = (count_d == '0);
    assign level_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/ft60x_tx_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : ft60x_tx_streamer
//  Description : FT60x 245-sync-FIFO write streamer. Buffers a valid/ready
//                word stream and bursts it to the FT60x whenever TXE_N allows.
//                Supports a counter test pattern, per-word byte enables and
//                words-sent / overflow status counters.
//  Ports       : clk, rst                 - FT CLKOUT, sync active-high reset
//                i_mode                   - 0 stream, 1 pattern, 2 idle
//                s_data/s_be/s_valid/s_ready - input word stream
//                io_ft_data/io_ft_be      - FT buses, driven only when writing
//                o_ft_wr_n/o_ft_oe_n/o_ft_rd_n - FT strobes
//                i_ft_txe_n               - FT has room when low
//                o_level                  - FIFO occupancy
//                o_words_sent             - words taken by FT (wraps)
//                o_overflow               - refused stream cycles (saturates)
//  Revision    : 1.0 - initial release
// ============================================================================
module ft60x_tx_streamer
    import ft60x_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int BE_W   = 2,
    parameter  int DEPTH  = 512,
    parameter  int CNT_W  = 32,
    localparam int LVL_W  = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] s_data,
    input  logic [BE_W-1:0]   s_be,
    input  logic              s_valid,
    output logic              s_ready,
    inout  wire  [DATA_W-1:0] io_ft_data,
    inout  wire  [BE_W-1:0]   io_ft_be,
    output logic              o_ft_wr_n,
    output logic              o_ft_oe_n,
    output logic              o_ft_rd_n,
    input  logic              i_ft_txe_n,
    output logic [LVL_W-1:0]  o_level,
    output logic [CNT_W-1:0]  o_words_sent,
    output logic [CNT_W-1:0]  o_overflow
);

    mode_e              mode_q, mode_d;
    logic               wr_n_q, wr_n_d;
    logic [DATA_W-1:0]  pat_q,  pat_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   ovf_q,  ovf_d;

    logic               w_take;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_empty_next;
    logic               w_src_avail;
    logic [DATA_W+BE_W-1:0] w_head;
    logic [DATA_W-1:0]  w_bus_data;
    logic [BE_W-1:0]    w_bus_be;

    // A word is consumed only on an edge where we strobe and the FT has room.
    assign w_take  = ~wr_n_q & ~i_ft_txe_n;
    assign w_pop   = w_take & (mode_q == MODE_STREAM);
    assign s_ready = ~rst & ~w_full & (mode_q != MODE_PATTERN);
    assign w_push  = s_valid & s_ready;

    ft_sync_fifo #(
        .WIDTH (DATA_W + BE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (w_push),
        .data_i       ({s_be, s_data}),
        .pop_i        (w_pop),
        .data_o       (w_head),
        .full_o       (w_full),
        .empty_next_o (w_empty_next),
        .level_o      (o_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_IDLE;
            wr_n_q <= 1'b1;
            pat_q  <= '0;
            sent_q <= '0;
            ovf_q  <= '0;
        end else begin
            mode_q <= mode_d;
            wr_n_q <= wr_n_d;
            pat_q  <= pat_d;
            sent_q <= sent_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        w_src_avail = 1'b0;
        pat_d       = pat_q;
        sent_d      = sent_q;
        ovf_d       = ovf_q;

        // Mode may only change while not strobing, which also guarantees no
        // transfer is in progress on this edge.
        if (wr_n_q) begin
            case (i_mode)
                2'd0:    mode_d = MODE_STREAM;
                2'd1:    mode_d = MODE_PATTERN;
                default: mode_d = MODE_IDLE;
            endcase
        end

        // Availability is judged for the cycle the strobe will be active,
        // i.e. after this edge's push/pop, so the last word is never repeated.
        case (mode_d)
            MODE_STREAM:  w_src_avail = ~w_empty_next;
            MODE_PATTERN: w_src_avail = 1'b1;
            default:      w_src_avail = 1'b0;
        endcase

        wr_n_d = ~(w_src_avail & ~i_ft_txe_n);

        if (w_take && (mode_q == MODE_PATTERN)) begin
            pat_d = pat_q + DATA_W'(1);
        end
        if (w_take) begin
            sent_d = sent_q + CNT_W'(1);
        end
        if (s_valid && !s_ready && (mode_q == MODE_STREAM) && !(&ovf_q)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    assign w_bus_data = (mode_q == MODE_PATTERN) ? pat_q     : w_head[DATA_W-1:0];
    assign w_bus_be   = (mode_q == MODE_PATTERN) ? {BE_W{1'b1}} : w_head[DATA_W+BE_W-1:DATA_W];

    assign io_ft_data = wr_n_q ? {DATA_W{1'bz}} : w_bus_data;
    assign io_ft_be   = wr_n_q ? {BE_W{1'bz}}   : w_bus_be;

    assign o_ft_wr_n    = wr_n_q;
    assign o_ft_oe_n    = 1'b1;
    assign o_ft_rd_n    = 1'b1;
    assign o_words_sent = sent_q;
    assign o_overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ft60x_tx_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ft60x_tx_streamer
//  Description : Directed self-checking bench for ft60x_tx_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ft60x_tx_streamer;

    localparam int DW    = 16;
    localparam int BW    = 2;
    localparam int DEPTH = 16;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode_in = 2'd0;
    logic [DW-1:0] s_data = '0;
    logic [BW-1:0] s_be = '1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    wire  [DW-1:0] ft_data;
    wire  [BW-1:0] ft_be;
    logic          ft_wr_n;
    logic          ft_oe_n;
    logic          ft_rd_n;
    logic          txe_n = 1'b0;
    logic [4:0]    level;
    logic [CW-1:0] words_sent;
    logic [CW-1:0] overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] obs_data[$];
    logic [BW-1:0] obs_be[$];
    int            wrn_low;
    int            stall_cnt;
    logic [DW-1:0] stall_word;

    ft60x_tx_streamer #(
        .DATA_W (DW),
        .BE_W   (BW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mode       (mode_in),
        .s_data       (s_data),
        .s_be         (s_be),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .io_ft_data   (ft_data),
        .io_ft_be     (ft_be),
        .o_ft_wr_n    (ft_wr_n),
        .o_ft_oe_n    (ft_oe_n),
        .o_ft_rd_n    (ft_rd_n),
        .i_ft_txe_n   (txe_n),
        .o_level      (level),
        .o_words_sent (words_sent),
        .o_overflow   (overflow)
    );

    // posedges at 5,15,...; stimulus changes on negedges
    always #5 clk = ~clk;

    // Bus monitor: samples 1 ns before each rising edge
    always @(negedge clk) begin
        #4;
        if (!rst && !ft_wr_n) begin
            wrn_low++;
            if (!txe_n) begin
                obs_data.push_back(ft_data);
                obs_be.push_back(ft_be);
            end else begin
                stall_cnt++;
                stall_word = ft_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_be.delete();
        wrn_low    = 0;
        stall_cnt  = 0;
        stall_word = '0;
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst     = 1'b1;
        mode_in = m;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", 64'(n), 64'd0);
        s_valid = 1'b1;
        s_data  = d;
        s_be    = be;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((level != 0 || !ft_wr_n) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, 64'(level == 0 && ft_wr_n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Test 1: reset state, empty FIFO with TXE_N low ----
        rst = 1'b1; mode_in = 2'd0; txe_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_wr_n",    64'(ft_wr_n), 64'd1);
        rst = 1'b0;
        clear_obs();
        repeat (4) @(negedge clk);
        check("idle_wr_n",     64'(ft_wr_n),    64'd1);
        check("idle_s_ready",  64'(s_ready),    64'd1);
        check("idle_level",    64'(level),      64'd0);
        check("idle_sent",     64'(words_sent), 64'd0);
        check("idle_overflow", 64'(overflow),   64'd0);
        check("idle_oe_rd",    {62'd0, ft_oe_n, ft_rd_n}, 64'd3);
        check("idle_no_words", 64'(obs_data.size()), 64'd0);

        // ---- Test 2: 16 words streamed back-to-back ----
        do_reset(2'd0);
        txe_n = 1'b0;
        for (int i = 1; i <= 16; i++) push(DW'(i), 2'b11);
        wait_drain("t2_drain");
        check("t2_count", 64'(obs_data.size()), 64'd16);
        for (int i = 0; i < obs_data.size() && i < 16; i++)
            check("t2_word", 64'(obs_data[i]), 64'(i + 1));
        check("t2_wrn_low", 64'(wrn_low),    64'd16);
        check("t2_sent",    64'(words_sent), 64'd16);

        // ---- Test 3: TXE_N rises on word 4 for 3 cycles ----
        do_reset(2'd0);
        txe_n = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(i), 2'b11);
        check("t3_level", 64'(level), 64'd8);
        clear_obs();
        txe_n = 1'b0;
        repeat (4) @(negedge clk);
        txe_n = 1'b1;
        repeat (3) @(negedge clk);
        txe_n = 1'b0;
        wait_drain("t3_drain");
        check("t3_count", 64'(obs_data.size()), 64'd8);
        for (int i = 0; i < obs_data.size() && i < 8; i++)
            check("t3_word", 64'(obs_data[i]), 64'(i + 1));
        check("t3_stall_cnt",  64'(stall_cnt),  64'd1);
        check("t3_stall_word", 64'(stall_word), 64'd4);
        check("t3_sent",       64'(words_sent), 64'd8);

        // ---- Test 4: fill, overflow, idle hold, then drain ----
        do_reset(2'd0);
        txe_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(DW'(16'h0100 + i), 2'b11);
        check("t4_full_ready", 64'(s_ready), 64'd0);
        check("t4_full_level", 64'(level),   64'd16);
        s_valid = 1'b1;
        s_data  = 16'h0BAD;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("t4_overflow",   64'(overflow), 64'd5);
        check("t4_level_hold", 64'(level),    64'd16);
        mode_in = 2'd2;
        @(negedge clk);
        txe_n = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_idle_wr_n", 64'(ft_wr_n),    64'd1);
        check("t4_idle_sent", 64'(words_sent), 64'd0);
        clear_obs();
        mode_in = 2'd0;
        wait_drain("t4_drain");
        check("t4_count", 64'(obs_data.size()), 64'd16);
        for (int i = 0; i < obs_data.size() && i < 16; i++)
            check("t4_word", 64'(obs_data[i]), 64'(16'h0100 + i));
        check("t4_sent", 64'(words_sent), 64'd16);

        // ---- Test 5: partial final word ----
        do_reset(2'd0);
        txe_n = 1'b1;
        push(16'h00A1, 2'b11);
        push(16'h00A2, 2'b11);
        push(16'h00A3, 2'b01);
        clear_obs();
        txe_n = 1'b0;
        wait_drain("t5_drain");
        check("t5_count", 64'(obs_be.size()), 64'd3);
        if (obs_be.size() == 3) begin
            check("t5_be0",   64'(obs_be[0]),   64'd3);
            check("t5_be1",   64'(obs_be[1]),   64'd3);
            check("t5_be2",   64'(obs_be[2]),   64'd1);
            check("t5_data2", 64'(obs_data[2]), 64'h00A3);
        end

        // ---- Test 6: counter pattern with TXE_N low 2 of every 4 cycles ----
        txe_n = 1'b1;
        do_reset(2'd1);
        check("t6_s_ready", 64'(s_ready), 64'd0);
        check("t6_wr_n",    64'(ft_wr_n), 64'd1);
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            txe_n = ((i % 4) >= 2);
            @(negedge clk);
        end
        txe_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_count", 64'(obs_data.size()), 64'd5);
        for (int i = 0; i < obs_data.size() && i < 5; i++) begin
            check("t6_word", 64'(obs_data[i]), 64'(i));
            check("t6_be",   64'(obs_be[i]),   64'd3);
        end
        check("t6_stalls", 64'(stall_cnt),  64'd5);
        check("t6_sent",   64'(words_sent), 64'd5);
        mode_in = 2'd2;

        // ---- Test 7: reset in the middle of a burst ----
        do_reset(2'd0);
        txe_n = 1'b1;
        for (int i = 1; i <= 6; i++) push(DW'(i), 2'b11);
        txe_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_mid_wr_n", 64'(ft_wr_n), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_wr_n",  64'(ft_wr_n), 64'd1);
        check("t7_rst_level", 64'(level),   64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_after_wr_n", 64'(ft_wr_n),    64'd1);
        check("t7_after_sent", 64'(words_sent), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
